// File: rtl/mips32_lane_ram.sv
// Block-RAM wrapper with one lane-masked write port and two write-first synchronous read ports.
// An optional output register adds a cycle of latency, and an optional post-reset sweep zeroes the array.
module mips32_lane_ram #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 32,
    parameter int LANES  = 4,
    parameter int OUTREG = 0,
    parameter int CLEAR  = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic [AWIDTH-1:0] readAddrA,
    input  logic              readEnableA,
    output logic [DWIDTH-1:0] readDataA,
    output logic              readValidA,
    input  logic [AWIDTH-1:0] readAddrB,
    input  logic              readEnableB,
    output logic [DWIDTH-1:0] readDataB,
    output logic              readValidB,
    input  logic [AWIDTH-1:0] writeAddr,
    input  logic [DWIDTH-1:0] writeData,
    input  logic [LANES-1:0]  writeLane,
    input  logic              writeEnable
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int LANEW = (LANES > 1) ? 8 : DWIDTH;

    typedef enum logic { SWEEP, RUN } stateType;

    logic [DWIDTH-1:0] mem [DEPTH];
    stateType          state, stateNext;
    logic [AWIDTH-1:0] clearCnt;
    logic              running;
    logic              wrActive;
    logic [LANES-1:0]  wrStrobe;
    logic [DWIDTH-1:0] wrMask, wrWord, mergedA, mergedB;
    logic [DWIDTH-1:0] dataA_p1, dataB_p1;
    logic              vldA_p1, vldB_p1;

    function automatic logic [DWIDTH-1:0] laneMask(input logic [LANES-1:0] strobes);
        logic [DWIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i*LANEW +: LANEW] = {LANEW{strobes[i]}};
        end
        return m;
    endfunction

    function automatic logic [DWIDTH-1:0] mergeLanes(input logic [DWIDTH-1:0] oldWord,
                                                     input logic [DWIDTH-1:0] newWord,
                                                     input logic [DWIDTH-1:0] mask);
        return (oldWord & ~mask) | (newWord & mask);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= (CLEAR != 0) ? SWEEP : RUN;
            clearCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == SWEEP) clearCnt <= clearCnt + 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        if (state == SWEEP && clearCnt == {AWIDTH{1'b1}}) stateNext = RUN;
    end

    assign running = (state == RUN);
    assign ready   = running;

    // Write-first merge: a same-edge write to the read address shows its written lanes.
    always_comb begin
        wrStrobe = (LANES == 1) ? {LANES{1'b1}} : writeLane;
        wrMask   = laneMask(wrStrobe);
        wrActive = running & writeEnable & ~reset;
        wrWord   = mergeLanes(mem[writeAddr], writeData, wrMask);
        mergedA  = mem[readAddrA];
        mergedB  = mem[readAddrB];
        if (wrActive && writeAddr == readAddrA) mergedA = mergeLanes(mem[readAddrA], writeData, wrMask);
        if (wrActive && writeAddr == readAddrB) mergedB = mergeLanes(mem[readAddrB], writeData, wrMask);
    end

    always_ff @(posedge clock) begin
        if (!reset && state == SWEEP) begin
            mem[clearCnt] <= '0;
        end else if (wrActive) begin
            mem[writeAddr] <= wrWord;
        end
    end

    // Stage p1: synchronous read register
    always_ff @(posedge clock) begin
        if (reset) begin
            dataA_p1 <= '0;
            dataB_p1 <= '0;
            vldA_p1  <= 1'b0;
            vldB_p1  <= 1'b0;
        end else begin
            vldA_p1 <= running & readEnableA;
            vldB_p1 <= running & readEnableB;
            if (running && readEnableA) dataA_p1 <= mergedA;
            if (running && readEnableB) dataB_p1 <= mergedB;
        end
    end

    // Stage p2: optional output register
    if (OUTREG != 0) begin : genOutReg
        logic [DWIDTH-1:0] dataA_p2, dataB_p2;
        logic              vldA_p2, vldB_p2;

        always_ff @(posedge clock) begin
            if (reset) begin
                dataA_p2 <= '0;
                dataB_p2 <= '0;
                vldA_p2  <= 1'b0;
                vldB_p2  <= 1'b0;
            end else begin
                dataA_p2 <= dataA_p1;
                dataB_p2 <= dataB_p1;
                vldA_p2  <= vldA_p1;
                vldB_p2  <= vldB_p1;
            end
        end

        assign readDataA  = dataA_p2;
        assign readDataB  = dataB_p2;
        assign readValidA = vldA_p2;
        assign readValidB = vldB_p2;
    end else begin : genDirect
        assign readDataA  = dataA_p1;
        assign readDataB  = dataB_p1;
        assign readValidA = vldA_p1;
        assign readValidB = vldB_p1;
    end

endmodule
